// File: rtl/sa_pkg.sv
// Shared state encoding and sizing helpers for the systolic-array sequencer.
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } sa_state_e;

  // Cycles needed to push the input skew out of an n x n array.
  function automatic int flush_cycles(input int n);
    return 2 * n - 2;
  endfunction

  function automatic int row_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sa_ctrl.sv
// sa_ctrl: sequences one output-stationary matmul job (clear, feed, flush, drain).
// Optional stall counter on stall_cnt is built only when SA_CTRL_PERF_CNT_EN is defined.
module sa_ctrl
  import sa_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   M_minus_one,
  input  logic               in_fifo_empty,
  input  logic               out_fifo_full,
  output logic               in_fifo_rd,
  output logic               array_en,
  output logic               array_zero,
  output logic               array_clear,
  output logic [$clog2(N)-1:0] drain_row,
  output logic               out_fifo_wr,
  output logic               busy,
  output logic               done,
  output logic [15:0]        stall_cnt,
  output sa_state_e          dbg_state
);

  localparam int ROW_W   = row_w(N);
  localparam int FLUSH_W = $clog2(2 * N - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(flush_cycles(N) - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(N - 1);

  sa_state_e          state;
  sa_state_e          state_nxt;
  logic [CNT_W-1:0]   m_lat;
  logic [CNT_W-1:0]   feed_cnt;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [ROW_W-1:0]   row_cnt;
  logic               feed_beat;
  logic               drain_beat;

  // Handshake: a word moves from the input FIFO only when in_fifo_empty=0 and the
  // sequencer is in FEED; a row moves to the output FIFO only when out_fifo_full=0
  // in DRAIN. Both strobes are combinational and forced low while rst is high.
  assign feed_beat   = (state == FEED)  && !in_fifo_empty && !rst;
  assign drain_beat  = (state == DRAIN) && !out_fifo_full && !rst;
  assign in_fifo_rd  = feed_beat;
  assign out_fifo_wr = drain_beat;
  assign array_en    = feed_beat || ((state == FLUSH) && !rst);
  assign drain_row   = row_cnt;
  assign dbg_state   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = FEED;
      FEED:    if (feed_beat && (feed_cnt == m_lat)) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == FLUSH_LAST) state_nxt = DRAIN;
      DRAIN:   if (drain_beat && (row_cnt == ROW_LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs are registered from the next state so they line up with it.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= IDLE;
      m_lat       <= '0;
      feed_cnt    <= '0;
      flush_cnt   <= '0;
      row_cnt     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      array_clear <= 1'b0;
      array_zero  <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      array_clear <= (state_nxt == CLEAR);
      array_zero  <= (state_nxt == FLUSH);
      case (state)
        IDLE:  if (start) m_lat <= M_minus_one;
        CLEAR: begin
          feed_cnt  <= '0;
          flush_cnt <= '0;
          row_cnt   <= '0;
        end
        FEED:  if (feed_beat && (feed_cnt != m_lat)) feed_cnt <= feed_cnt + 1'b1;
        FLUSH: if (flush_cnt != FLUSH_LAST) flush_cnt <= flush_cnt + 1'b1;
        DRAIN: if (drain_beat && (row_cnt != ROW_LAST)) row_cnt <= row_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SA_CTRL_PERF_CNT_EN
  logic [15:0] stall_q;
  logic        stalled;

  assign stalled = ((state == FEED) && in_fifo_empty) || ((state == DRAIN) && out_fifo_full);

  always_ff @(posedge sys_clk) begin
    if (rst || (state == CLEAR)) begin
      stall_q <= '0;
    end else if (stalled && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sa_ctrl.sv
// Directed self-checking bench for sa_ctrl (N=4); drain rows are scoreboarded.
module tb_sa_ctrl;
  import sa_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = 8;
  localparam int ROW_W = $clog2(N);

  logic              sys_clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  M_minus_one;
  logic              in_fifo_empty;
  logic              out_fifo_full;
  logic              in_fifo_rd;
  logic              array_en;
  logic              array_zero;
  logic              array_clear;
  logic [ROW_W-1:0]  drain_row;
  logic              out_fifo_wr;
  logic              busy;
  logic              done;
  logic [15:0]       stall_cnt;
  sa_state_e         dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int rd_beats, wr_beats, en_cycles, zero_cycles, clear_cycles;
  logic [ROW_W-1:0] exp_q[$];
  logic [ROW_W-1:0] exp_row;

  sa_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .start         (start),
    .M_minus_one   (M_minus_one),
    .in_fifo_empty (in_fifo_empty),
    .out_fifo_full (out_fifo_full),
    .in_fifo_rd    (in_fifo_rd),
    .array_en      (array_en),
    .array_zero    (array_zero),
    .array_clear   (array_clear),
    .drain_row     (drain_row),
    .out_fifo_wr   (out_fifo_wr),
    .busy          (busy),
    .done          (done),
    .stall_cnt     (stall_cnt),
    .dbg_state     (dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: counts strobes and checks each write against the scoreboard.
  always @(negedge sys_clk) begin
    if (!rst) begin
      if (in_fifo_rd) begin
        rd_beats++;
        check("rd_while_empty", in_fifo_empty, 0);
      end
      if (array_en)    en_cycles++;
      if (array_zero)  zero_cycles++;
      if (array_clear) clear_cycles++;
      if (out_fifo_wr) begin
        wr_beats++;
        check("wr_while_full", out_fifo_full, 0);
        check("wr_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_row = exp_q.pop_front();
          check("drain_row", drain_row, exp_row);
        end
      end
    end
  end

  task automatic check_all_zero(input string pfx);
    check({pfx, "_in_fifo_rd"},  in_fifo_rd, 0);
    check({pfx, "_array_en"},    array_en, 0);
    check({pfx, "_array_zero"},  array_zero, 0);
    check({pfx, "_array_clear"}, array_clear, 0);
    check({pfx, "_drain_row"},   drain_row, 0);
    check({pfx, "_out_fifo_wr"}, out_fifo_wr, 0);
    check({pfx, "_busy"},        busy, 0);
    check({pfx, "_done"},        done, 0);
    check({pfx, "_stall_cnt"},   stall_cnt, 0);
    check({pfx, "_state"},       32'(dbg_state), 32'(IDLE));
  endtask

  task automatic run_job(input int m1, input int gap_after, input int gap_len,
                         input int full_at, input int full_len, input bit repulse,
                         input int rst_at);
    int  gap_left, full_left, lat, exp_lat, exp_stall;
    bit  gap_on, full_on, got_done, aborted;
    time t_start;
    gap_left  = gap_len;
    full_left = full_len;
    gap_on    = 1'b0;
    full_on   = 1'b0;
    got_done  = 1'b0;
    aborted   = 1'b0;
    lat       = 0;
    exp_lat   = 1 + (m1 + 1) + (2 * N - 2) + N + gap_len + full_len;
`ifdef SA_CTRL_PERF_CNT_EN
    exp_stall = gap_len + full_len;
`else
    exp_stall = 0;
`endif
    @(posedge sys_clk); #1;
    M_minus_one   = CNT_W'(m1);
    start         = 1'b1;
    in_fifo_empty = 1'b0;
    out_fifo_full = 1'b0;
    @(posedge sys_clk);
    t_start      = $time;
    rd_beats     = 0;
    wr_beats     = 0;
    en_cycles    = 0;
    zero_cycles  = 0;
    clear_cycles = 0;
    for (int k = 0; k < N; k++) exp_q.push_back(ROW_W'(k));
    #1 start = 1'b0;
    for (int c = 0; c < 4000 && !got_done && !aborted; c++) begin
      if (gap_len > 0 && !gap_on && rd_beats == gap_after) gap_on = 1'b1;
      in_fifo_empty = gap_on && (gap_left > 0);
      if (in_fifo_empty) gap_left--;
      if (full_len > 0 && !full_on && wr_beats == full_at) full_on = 1'b1;
      out_fifo_full = full_on && (full_left > 0);
      if (out_fifo_full) full_left--;
      if (repulse) begin
        start = (c == 3) || (c == 4);
        if (c == 3) M_minus_one = '0;
      end
      if (rst_at >= 0 && wr_beats == rst_at) begin
        rst           = 1'b1;
        out_fifo_full = 1'b0;
        @(negedge sys_clk);
        check("rst_cycle_rd", in_fifo_rd, 0);
        check("rst_cycle_wr", out_fifo_wr, 0);
        @(posedge sys_clk); #1;
        rst = 1'b0;
        @(negedge sys_clk);
        check_all_zero("after_rst");
        exp_q.delete();
        aborted = 1'b1;
      end else begin
        @(negedge sys_clk);
        if (c == 0) begin
          check("busy_after_start", busy, 1);
          check("clear_pulse", array_clear, 1);
        end
        if (out_fifo_full) begin
          check("row_hold_full", drain_row, full_at);
          check("no_wr_full", out_fifo_wr, 0);
        end
        if (done) begin
          got_done = 1'b1;
          lat = int'(($time - t_start - 5) / 10);
        end else begin
          @(posedge sys_clk); #1;
        end
      end
    end
    start = 1'b0;
    if (!aborted) begin
      check("done_seen", got_done, 1);
      if (got_done) begin
        check("latency", lat, exp_lat);
        check("busy_in_done", busy, 1);
        check("rd_beats", rd_beats, m1 + 1);
        check("en_cycles", en_cycles, m1 + 1 + 2 * N - 2);
        check("zero_cycles", zero_cycles, 2 * N - 2);
        check("clear_cycles", clear_cycles, 1);
        check("wr_beats", wr_beats, N);
        check("scoreboard_empty", exp_q.size(), 0);
        check("stall_cnt", stall_cnt, exp_stall);
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        check("stall_cnt_hold", stall_cnt, exp_stall);
      end
      exp_q.delete();
    end
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    M_minus_one   = '0;
    in_fifo_empty = 1'b1;
    out_fifo_full = 1'b1;
    rd_beats = 0; wr_beats = 0; en_cycles = 0; zero_cycles = 0; clear_cycles = 0;
    @(posedge sys_clk);
    @(posedge sys_clk); #1;
    rst = 1'b0;
    @(negedge sys_clk);
    check_all_zero("reset");

    run_job(3, 0, 0, 0, 0, 1'b0, -1);
    run_job(3, 2, 3, 0, 0, 1'b0, -1);
    run_job(3, 0, 0, 2, 2, 1'b0, -1);
    run_job(255, 0, 0, 0, 0, 1'b0, -1);
    run_job(3, 0, 0, 0, 0, 1'b1, -1);
    run_job(3, 0, 0, 0, 0, 1'b0, 1);
    run_job(3, 0, 0, 0, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
